// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes,
// datapath select encodings and the control-vector type.
package mips_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_IMMEX    = 4'd10;
  localparam logic [3:0] S_IMMWB    = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       ext_op;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decoder: current state (+ opcode for immediate ops, mem_ready
// for the fetch strobes) to the full datapath control vector.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic is_addi;
  assign is_addi = (opcode == OP_ADDI);

  always_comb begin
    // NOTE: default every field first so no path through the case infers a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ext_op    = 1'b1;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ext_op    = 1'b1;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = is_addi ? ALU_ADD : ALU_LOGIC;
        ctrl.ext_op    = is_addi;
      end
      // Extension mode stays stable through write-back so the immediate path is glitch-free.
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.ext_op    = is_addi;
      end
      S_ILLEGAL: ctrl.illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, memory wait counter with
// timeout, and reset-gated datapath controls.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       ext_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       bus_error,
  output logic       illegal_op,
  output logic [3:0] estado
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  logic [3:0]       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             mem_state, timeout;
  ctrl_t            ctrl, ctrl_out;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == TIMEOUT_CNT);

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                  state_next = S_EXECUTE;
          OP_LW, OP_SW:              state_next = S_MEMADR;
          OP_BEQ:                    state_next = S_BRANCH;
          OP_J:                      state_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_next = S_IMMEX;
          default:                   state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_SW) ? S_MEMWRITE :
                               (opcode == OP_LW) ? S_MEMREAD  : S_FETCH;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB :
                               timeout   ? S_FETCH : S_MEMREAD;
      S_MEMWRITE: state_next = (mem_ready || timeout) ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_next = S_ALUWB;
      S_IMMEX:    state_next = S_IMMWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Counting only while stalled in a memory state also clears it on every state change.
  assign wait_cnt_next = (mem_state && !mem_ready && !timeout) ? wait_cnt + 1'b1 : '0;

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  mips_ctrl_decode u_decode (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign ctrl_out = reset ? '0 : ctrl;

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign i_or_d        = ctrl_out.i_or_d;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign ext_op        = ctrl_out.ext_op;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign pc_source     = ctrl_out.pc_source;
  assign illegal_op    = ctrl_out.illegal_op;
  assign bus_error     = timeout && !reset;
  assign estado        = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: a per-cycle vector table for
// instruction flows plus hand-written timeout and reset sequences.
module tb_mips_multicycle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       bus_error, illegal_op;
  logic [3:0] estado;

  int checks = 0;
  int failures = 0;

  mips_multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .ext_op(ext_op), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .bus_error(bus_error),
    .illegal_op(illegal_op), .estado(estado)
  );

  always #5 clock = ~clock;

  // Observed control word, bit 18 down to 0.
  logic [18:0] act_ctl;
  assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op,
                    alu_src_b, alu_op, pc_source, bus_error, illegal_op};

  localparam logic [18:0] PCW  = 19'd1 << 18;
  localparam logic [18:0] PCWC = 19'd1 << 17;
  localparam logic [18:0] IORD = 19'd1 << 16;
  localparam logic [18:0] MR   = 19'd1 << 15;
  localparam logic [18:0] MW   = 19'd1 << 14;
  localparam logic [18:0] IRW  = 19'd1 << 13;
  localparam logic [18:0] M2R  = 19'd1 << 12;
  localparam logic [18:0] RDST = 19'd1 << 11;
  localparam logic [18:0] RW   = 19'd1 << 10;
  localparam logic [18:0] ASA  = 19'd1 << 9;
  localparam logic [18:0] EXT  = 19'd1 << 8;
  localparam logic [18:0] BERR = 19'd1 << 1;
  localparam logic [18:0] ILL  = 19'd1;

  function automatic logic [18:0] fb(input logic [1:0] v); return {11'd0, v, 6'd0}; endfunction
  function automatic logic [18:0] fa(input logic [1:0] v); return {13'd0, v, 4'd0}; endfunction
  function automatic logic [18:0] fp(input logic [1:0] v); return {15'd0, v, 2'd0}; endfunction

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, ORI = 6'b001101, BAD = 6'b111111;

  logic [18:0] c_fnr, c_fr, c_dec, c_madr, c_mrd, c_mwb, c_mwr, c_exe, c_awb;
  logic [18:0] c_br, c_jmp, c_imx_a, c_imx_l, c_imw_a, c_imw_l, c_ill;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic        chk_st;
    logic [3:0]  st;
    logic [18:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                     input logic chk_st, input logic [3:0] st, input logic [18:0] ctl);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.chk_st = chk_st; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, compare the settled outputs, then clock.
  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input logic chk_st, input logic [3:0] st, input logic [18:0] ctl,
                      input string tag);
    reset = rst; opcode = op; mem_ready = mr;
    #2;
    if (chk_st) check({tag, " estado"}, 32'(estado), 32'(st));
    check({tag, " ctl"}, 32'(act_ctl), 32'(ctl));
    @(posedge clock);
    #1;
  endtask

  initial begin
    c_fnr   = MR | fb(2'b01);
    c_fr    = c_fnr | IRW | PCW;
    c_dec   = fb(2'b11) | EXT;
    c_madr  = ASA | fb(2'b10) | EXT;
    c_mrd   = MR | IORD;
    c_mwb   = RW | M2R;
    c_mwr   = MW | IORD;
    c_exe   = ASA | fa(2'b10);
    c_awb   = RDST | RW;
    c_br    = ASA | fa(2'b01) | PCWC | fp(2'b01);
    c_jmp   = PCW | fp(2'b10);
    c_imx_a = ASA | fb(2'b10) | EXT;
    c_imx_l = ASA | fb(2'b10) | fa(2'b11);
    c_imw_a = RW | EXT;
    c_imw_l = RW;
    c_ill   = ILL;

    add(1, RT, 1, 0, 0, 19'd0);
    add(1, RT, 1, 1, 0, 19'd0);
    add(0, LW, 1, 1, 0, c_fr);   add(0, LW, 1, 1, 1, c_dec);   add(0, LW, 1, 1, 2, c_madr);
    add(0, LW, 1, 1, 3, c_mrd);  add(0, LW, 1, 1, 4, c_mwb);
    add(0, ORI, 1, 1, 0, c_fr);  add(0, ORI, 1, 1, 1, c_dec);
    add(0, ORI, 1, 1, 10, c_imx_l); add(0, ORI, 1, 1, 11, c_imw_l);
    add(0, ADDI, 1, 1, 0, c_fr); add(0, ADDI, 1, 1, 1, c_dec);
    add(0, ADDI, 1, 1, 10, c_imx_a); add(0, ADDI, 1, 1, 11, c_imw_a);
    add(0, RT, 1, 1, 0, c_fr);   add(0, RT, 1, 1, 1, c_dec);
    add(0, RT, 1, 1, 6, c_exe);  add(0, RT, 1, 1, 7, c_awb);
    add(0, BEQ, 1, 1, 0, c_fr);  add(0, BEQ, 1, 1, 1, c_dec);  add(0, BEQ, 1, 1, 8, c_br);
    add(0, JMP, 1, 1, 0, c_fr);  add(0, JMP, 1, 1, 1, c_dec);  add(0, JMP, 1, 1, 9, c_jmp);
    add(0, BAD, 1, 1, 0, c_fr);  add(0, BAD, 1, 1, 1, c_dec);  add(0, BAD, 1, 1, 12, c_ill);
    add(0, RT, 0, 1, 0, c_fnr);  add(0, RT, 0, 1, 0, c_fnr);   add(0, RT, 0, 1, 0, c_fnr);
    add(0, RT, 1, 1, 0, c_fr);   add(0, RT, 0, 1, 1, c_dec);
    add(0, RT, 0, 1, 6, c_exe);  add(0, RT, 0, 1, 7, c_awb);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].chk_st, vecs[i].st, vecs[i].ctl,
           $sformatf("vec%0d", i));

    // sw with memory never ready: 15 wait cycles, timeout on the 16th, back to FETCH.
    step(0, SW, 1, 1, 0, c_fr, "sw fetch");
    step(0, SW, 0, 1, 1, c_dec, "sw decode");
    step(0, SW, 0, 1, 2, c_madr, "sw memadr");
    for (int i = 0; i < 15; i++) step(0, SW, 0, 1, 5, c_mwr, $sformatf("sw wait%0d", i));
    reset = 1'b0; opcode = SW; mem_ready = 1'b0;
    #2;
    check("sw timeout bus_error", 32'(bus_error), 32'd1);
    check("sw timeout estado", 32'(estado), 32'd5);
    check("sw timeout strobes", 32'({reg_write, ir_write, pc_write, pc_write_cond}), 32'd0);
    @(posedge clock); #1;
    step(0, SW, 0, 1, 0, c_fnr, "sw after timeout");

    // lw where mem_ready arrives exactly in the timeout cycle: completes normally.
    step(0, LW, 1, 1, 0, c_fr, "lwt fetch");
    step(0, LW, 0, 1, 1, c_dec, "lwt decode");
    step(0, LW, 0, 1, 2, c_madr, "lwt memadr");
    for (int i = 0; i < 15; i++) step(0, LW, 0, 1, 3, c_mrd, $sformatf("lwt wait%0d", i));
    step(0, LW, 1, 1, 3, c_mrd, "lwt ready at limit");
    step(0, LW, 0, 1, 4, c_mwb, "lwt writeback");

    // Fetch timeout: restart fetch in place, counter cleared afterwards.
    for (int i = 0; i < 15; i++) step(0, LW, 0, 1, 0, c_fnr, $sformatf("ft wait%0d", i));
    step(0, LW, 0, 1, 0, c_fnr | BERR, "ft timeout");
    step(0, LW, 0, 1, 0, c_fnr, "ft cleared");

    // Reset while stalled in MEMREAD with a partly advanced wait counter.
    step(0, LW, 1, 1, 0, c_fr, "rst fetch");
    step(0, LW, 0, 1, 1, c_dec, "rst decode");
    step(0, LW, 0, 1, 2, c_madr, "rst memadr");
    for (int i = 0; i < 10; i++) step(0, LW, 0, 1, 3, c_mrd, $sformatf("rst wait%0d", i));
    step(1, LW, 1, 0, 0, 19'd0, "rst in memread");
    for (int i = 0; i < 15; i++) step(0, RT, 0, 1, 0, c_fnr, $sformatf("post rst%0d", i));
    step(0, RT, 0, 1, 0, c_fnr | BERR, "post rst timeout");
    step(1, RT, 1, 1, 0, 19'd0, "rst in fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
